// File: rtl/sat_engine_pkg.sv
// Shared definitions for the clause-array load/store sequencer: state encoding and record width.
package sat_engine_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LD_REQ  = 3'd1;
    localparam logic [2:0] S_LD_WAIT = 3'd2;
    localparam logic [2:0] S_LD_WR   = 3'd3;
    localparam logic [2:0] S_CLR     = 3'd4;
    localparam logic [2:0] S_ST_RD   = 3'd5;
    localparam logic [2:0] S_ST_WR   = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    typedef enum logic [2:0] {
        IDLE    = S_IDLE,
        LD_REQ  = S_LD_REQ,
        LD_WAIT = S_LD_WAIT,
        LD_WR   = S_LD_WR,
        CLR     = S_CLR,
        ST_RD   = S_ST_RD,
        ST_WR   = S_ST_WR,
        DONE    = S_DONE
    } ldst_state_t;

    // Bin-memory record layout is {len, lits}.
    function automatic int rec_width(input int num_vars, input int width_c_len);
        return num_vars * 2 + width_c_len;
    endfunction

endpackage

// File: rtl/slot_onehot.sv
// Slot index to one-hot strobe decoder; all zero when disabled or index out of range.
module slot_onehot #(
    parameter int N  = 8,
    parameter int IW = 4
) (
    input  logic [IW-1:0] idx,
    input  logic          en,
    output logic [N-1:0]  oh
);

    always_comb begin
        oh = '0;
        for (int i = 0; i < N; i++) begin
            oh[i] = en && (idx == IW'(i));
        end
    end

endmodule

// File: rtl/clause_array_ldst.sv
// Clause-array load/store sequencer between the bin memory and the clause slots.
// Optional build macro CLAUSE_ST_SKIP_REASON_EN: stores skip slots whose length is 0.
//
// state   | meaning
// IDLE    | waiting for a start command
// LD_REQ  | one-cycle bin-memory read request for slot k
// LD_WAIT | waiting for read data
// LD_WR   | write registered record into slot k
// CLR     | zero-fill slot k (k = n .. NUM_CLAUSES-1)
// ST_RD   | read strobe on slot k, capture its record
// ST_WR   | write captured record to memory, hold until ack
// DONE    | one-cycle completion pulse
module clause_array_ldst
    import sat_engine_pkg::*;
#(
    parameter int NUM_VARS    = 8,
    parameter int NUM_CLAUSES = 8,
    parameter int WIDTH_C_LEN = 4,
    parameter int WIDTH_ADDR  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_load_i,
    input  logic                              start_store_i,
    input  logic [WIDTH_ADDR-1:0]             base_addr_i,
    input  logic [WIDTH_C_LEN+3:0]            num_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [WIDTH_C_LEN+3:0]            xfer_cnt_o,
    output logic                              mem_rd_req_o,
    output logic [WIDTH_ADDR-1:0]             mem_rd_addr_o,
    input  logic                              mem_rd_valid_i,
    input  logic [NUM_VARS*2+WIDTH_C_LEN-1:0] mem_rd_data_i,
    output logic                              mem_wr_o,
    output logic [WIDTH_ADDR-1:0]             mem_wr_addr_o,
    output logic [NUM_VARS*2+WIDTH_C_LEN-1:0] mem_wr_data_o,
    input  logic                              mem_wr_ack_i,
    output logic [NUM_CLAUSES-1:0]            wr_o,
    output logic [NUM_CLAUSES-1:0]            rd_o,
    output logic [NUM_VARS*2-1:0]             clause_o,
    output logic [WIDTH_C_LEN-1:0]            clause_len_o,
    input  logic [NUM_VARS*2-1:0]             clause_i,
    input  logic [WIDTH_C_LEN*NUM_CLAUSES-1:0] clause_len_i
);

    localparam int REC_W = rec_width(NUM_VARS, WIDTH_C_LEN);
    localparam int LW    = NUM_VARS * 2;
    localparam int NW    = WIDTH_C_LEN + 4;
    localparam int KW    = $clog2(NUM_CLAUSES + 1);

    ldst_state_t           state, state_d;
    logic [KW-1:0]         k, k_d, k_inc, n, n_d;
    logic [WIDTH_ADDR-1:0] base, base_d;
    logic [NW-1:0]         cnt_d;
    logic [WIDTH_C_LEN-1:0] len_sel;
    logic                  skip, wr_new, dec_en;
    logic [NUM_CLAUSES-1:0] dec_oh;

    assign k_inc = k + KW'(1);

    always_comb begin
        len_sel = '0;
        for (int i = 0; i < NUM_CLAUSES; i++) begin
            if (k == KW'(i)) len_sel = clause_len_i[i*WIDTH_C_LEN +: WIDTH_C_LEN];
        end
    end

`ifdef CLAUSE_ST_SKIP_REASON_EN
    assign skip   = (mem_wr_data_o[REC_W-1 -: WIDTH_C_LEN] == '0);
    assign wr_new = (len_sel != '0);
`else
    assign skip   = 1'b0;
    assign wr_new = 1'b1;
`endif

    always_comb begin
        state_d = state;
        k_d     = k;
        n_d     = n;
        base_d  = base;
        cnt_d   = xfer_cnt_o;
        case (state)
            IDLE: begin
                if (start_load_i || start_store_i) begin
                    n_d    = (num_i > NW'(NUM_CLAUSES)) ? KW'(NUM_CLAUSES) : KW'(num_i);
                    base_d = base_addr_i;
                    k_d    = '0;
                    cnt_d  = '0;
                    if (start_load_i) state_d = (n_d == '0) ? CLR : LD_REQ;
                    else              state_d = (n_d == '0) ? DONE : ST_RD;
                end
            end
            LD_REQ:  state_d = LD_WAIT;
            LD_WAIT: if (mem_rd_valid_i) state_d = LD_WR;
            LD_WR: begin
                cnt_d = xfer_cnt_o + NW'(1);
                k_d   = k_inc;
                if (k_inc < n)                        state_d = LD_REQ;
                else if (k_inc < KW'(NUM_CLAUSES))    state_d = CLR;
                else                                  state_d = DONE;
            end
            CLR: begin
                k_d     = k_inc;
                state_d = (k_inc < KW'(NUM_CLAUSES)) ? CLR : DONE;
            end
            ST_RD: state_d = ST_WR;
            ST_WR: begin
                if (mem_wr_ack_i || skip) begin
                    if (!skip) cnt_d = xfer_cnt_o + NW'(1);
                    k_d     = k_inc;
                    state_d = (k_inc < n) ? ST_RD : DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One decoder serves both strobes; they never share a state.
    assign dec_en = (state_d == LD_WR) || (state_d == CLR) || (state_d == ST_RD);

    slot_onehot #(.N(NUM_CLAUSES), .IW(KW)) u_slot_onehot (
        .idx (k_d),
        .en  (dec_en),
        .oh  (dec_oh)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            k             <= '0;
            n             <= '0;
            base          <= '0;
            xfer_cnt_o    <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            mem_rd_req_o  <= 1'b0;
            mem_rd_addr_o <= '0;
            mem_wr_o      <= 1'b0;
            mem_wr_addr_o <= '0;
            mem_wr_data_o <= '0;
            wr_o          <= '0;
            rd_o          <= '0;
            clause_o      <= '0;
            clause_len_o  <= '0;
        end else begin
            state        <= state_d;
            k            <= k_d;
            n            <= n_d;
            base         <= base_d;
            xfer_cnt_o   <= cnt_d;
            busy_o       <= (state_d != IDLE) && (state_d != DONE);
            done_o       <= (state_d == DONE);
            mem_rd_req_o <= (state_d == LD_REQ);
            if (state_d == LD_REQ) mem_rd_addr_o <= base_d + WIDTH_ADDR'(k_d);
            wr_o <= ((state_d == LD_WR) || (state_d == CLR)) ? dec_oh : '0;
            rd_o <= (state_d == ST_RD) ? dec_oh : '0;
            if (state_d == LD_WR) begin
                clause_o     <= mem_rd_data_i[LW-1:0];
                clause_len_o <= mem_rd_data_i[REC_W-1 -: WIDTH_C_LEN];
            end else begin
                clause_o     <= '0;
                clause_len_o <= '0;
            end
            if (state == ST_RD) begin
                mem_wr_data_o <= {len_sel, clause_i};
                mem_wr_addr_o <= base + WIDTH_ADDR'(k);
            end
            // Held while waiting for ack; a skipped slot never raises it.
            mem_wr_o <= (state_d == ST_WR) && ((state == ST_WR) ? mem_wr_o : wr_new);
        end
    end

endmodule
